// File: rtl/vga_pattern_sequencer_pkg.sv
// Shared scan-geometry constants, state encoding and sizing helper for the
// VGA pattern sequencer and its button front end.
package vga_pattern_sequencer_pkg;

    // Scan position width and the row on which vertical blanking starts.
    localparam int PIXEL_W       = 10;
    localparam int BLANK_START_X = 0;
    localparam int BLANK_START_Y = 480;

    // Run/pause controller state.
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_PAUSE = 1'b1
    } seq_state_t;

    // Width needed to hold 0..n-1, never less than one bit.
    function automatic int safe_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Raw push-button front end: two-flop synchronizer, stability counter and a
// one-cycle pulse on each debounced press (releases produce nothing).
module button_debounce
    import vga_pattern_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk_d,
    input  logic rst,
    input  logic btn_i,
    output logic press_o
);

    localparam int CNT_W = safe_clog2(DEBOUNCE_CYCLES);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count consecutive cycles that disagree with the debounced level; any agreement restarts.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchronizer, counter, debounced level and press pulse registers.
    always_ff @(posedge clk_d) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/vga_pattern_sequencer.sv
// Frame-synchronous pattern/scroll controller. All visible outputs change only
// on the frame tick at the start of vertical blanking, so a frame never shows
// a mix of two patterns.
module vga_pattern_sequencer
    import vga_pattern_sequencer_pkg::*;
#(
    parameter int NUM_PATTERNS    = 4,
    parameter int FRAMES_PER_STEP = 60,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int SCROLL_WRAP     = 480
) (
    input  logic                                clk_d,
    input  logic                                rst,
    input  logic                                video_on,
    input  logic [PIXEL_W-1:0]                  pixel_x,
    input  logic [PIXEL_W-1:0]                  pixel_y,
    input  logic                                btn_next,
    input  logic                                btn_mode,
    output logic [safe_clog2(NUM_PATTERNS)-1:0] pattern_sel,
    output logic [PIXEL_W-1:0]                  scroll_x,
    output logic                                paused,
    output logic                                frame_tick
);

    localparam int PAT_W  = safe_clog2(NUM_PATTERNS);
    localparam int STEP_W = safe_clog2(FRAMES_PER_STEP);

    logic              next_press, mode_press;
    logic              hit, hit_q, tick_q;
    logic              next_pend_q, next_pend_d;
    logic              mode_pend_q, mode_pend_d;
    logic              advance;
    seq_state_t        state_q, state_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [PIXEL_W-1:0] scroll_q, scroll_d;
    logic [STEP_W-1:0]  step_q, step_d;

    // video_on is informational only; the tick is derived from the scan position.
    logic unused_video_on;
    assign unused_video_on = video_on;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next_db (
        .clk_d   (clk_d),
        .rst     (rst),
        .btn_i   (btn_next),
        .press_o (next_press)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
        .clk_d   (clk_d),
        .rst     (rst),
        .btn_i   (btn_mode),
        .press_o (mode_press)
    );

    assign hit     = (pixel_y == PIXEL_W'(BLANK_START_Y)) && (pixel_x == PIXEL_W'(BLANK_START_X));
    assign advance = next_pend_q || (state_q == ST_RUN && step_q == STEP_W'(FRAMES_PER_STEP - 1));

    // Next-state for the FSM, counters and pending flags; frame updates use pre-tick state.
    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        scroll_d    = scroll_q;
        step_d      = step_q;
        // A press coinciding with the tick survives the clear and waits for the next tick.
        next_pend_d = next_press | (next_pend_q & ~tick_q);
        mode_pend_d = mode_press | (mode_pend_q & ~tick_q);
        if (tick_q) begin
            if (state_q == ST_RUN) begin
                scroll_d = (scroll_q == PIXEL_W'(SCROLL_WRAP - 1)) ? '0 : scroll_q + 1'b1;
                step_d   = step_q + 1'b1;
            end
            if (advance) begin
                pat_d  = (pat_q == PAT_W'(NUM_PATTERNS - 1)) ? '0 : pat_q + 1'b1;
                step_d = '0;
            end
            if (mode_pend_q) begin
                state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
            end
        end
    end

    // State register plus tick detect, pending flags and frame counters.
    always_ff @(posedge clk_d) begin
        if (rst) begin
            state_q     <= ST_RUN;
            hit_q       <= 1'b0;
            tick_q      <= 1'b0;
            next_pend_q <= 1'b0;
            mode_pend_q <= 1'b0;
            pat_q       <= '0;
            scroll_q    <= '0;
            step_q      <= '0;
        end else begin
            state_q     <= state_d;
            hit_q       <= hit;
            tick_q      <= hit & ~hit_q;
            next_pend_q <= next_pend_d;
            mode_pend_q <= mode_pend_d;
            pat_q       <= pat_d;
            scroll_q    <= scroll_d;
            step_q      <= step_d;
        end
    end

    assign pattern_sel = pat_q;
    assign scroll_x    = scroll_q;
    assign paused      = (state_q == ST_PAUSE);
    assign frame_tick  = tick_q;

endmodule
